take_msb: RTL and testbench
===========================

TAKE_MSB -- requirements
Module: take_msb

Interface
REQ-001 Parameter WIDTH, default 8: input word width, minimum 4.
REQ-002 Parameter MSB_BIT, default 3: threshold bit position, where out=1 iff in >= 2**MSB_BIT; legal range 0..WIDTH-1.
REQ-003 Port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port in, input, WIDTH bits: unsigned data word.
REQ-006 Port out, output, 1 bit: combinational threshold flag.
REQ-007 Port clr, input, 1 bit: synchronous clear of peak state, active-high.
REQ-008 Port out_q, output, 1 bit: registered copy of out.
REQ-009 Port msb_idx, output, clog2(WIDTH) bits: registered index of highest set bit of in.
REQ-010 Port msb_vld, output, 1 bit: registered; 1 iff in != 0.
REQ-011 Port peak_idx, output, clog2(WIDTH) bits: present only with TAKE_MSB_PEAK_EN; highest msb_idx captured since reset or clr.

Function
REQ-012 out SHALL equal OR of in[WIDTH-1:MSB_BIT], purely combinational, zero cycles latency, independent of clk, rst_n and clr.
REQ-013 Defaults: out=1 for in>=0x08 (0x08, 0x09, 0xFF); out=0 for 0x00..0x07.
REQ-014 out SHALL never be X when in is fully 0/1.
REQ-015 On each rising clk edge, out_q SHALL capture out (1-cycle latency).
REQ-016 On each rising clk edge, msb_idx SHALL capture the index of the highest set bit of in (priority encoder, MSB wins); msb_vld SHALL capture (in != 0).
REQ-017 When in == 0, msb_idx SHALL capture 0 and msb_vld 0.
REQ-018 Boundaries: in=0x01 gives msb_idx=0; in=0x80 gives 7; in=0xFF gives 7.
REQ-019 Peak (if enabled): on each edge with msb_vld-next=1 and new index > peak_idx, peak_idx SHALL load the new index; otherwise it holds.
REQ-020 Peak: clr=1 on an edge SHALL load peak_idx=0, taking priority over a simultaneous capture.
REQ-021 All arithmetic unsigned; no saturation/wrap issues arise, as indices are bounded by WIDTH-1.

Reset
REQ-022 rst_n=0 SHALL immediately force out_q=0, msb_idx=0, msb_vld=0, peak_idx=0, regardless of clk.
REQ-023 Registers SHALL resume capture on the first rising clk edge after rst_n deasserts.
REQ-024 out is unaffected by reset and follows in at all times, including during reset.
REQ-025 Reset asserted mid-operation SHALL discard all held state; peak SHALL restart from 0.

Configuration
REQ-026 Macro TAKE_MSB_PEAK_EN defined: peak_idx port, peak register and clr-driven clear logic are compiled in, per REQ-019/020.
REQ-027 Macro TAKE_MSB_PEAK_EN undefined: peak_idx port and peak logic are absent; clr remains a port and is ignored.
REQ-028 The macro SHALL NOT affect out, out_q, msb_idx or msb_vld.

Verification
REQ-029 Combinational sweep: in=0xFF, 0x00..0x09 with 10 ns settle each, no clock -> out=1, 0 (x8 for 0x00..0x07), 1, 1.
REQ-030 Registered path: rst_n=1, in=0x09, one edge -> out_q=1, msb_idx=3, msb_vld=1; then in=0x00, one edge -> out_q=0, msb_idx=0, msb_vld=0.
REQ-031 Priority encoder: in=0x01, 0x80, 0xFF, 0x24, one edge each -> msb_idx=0, 7, 7, 5.
REQ-032 Async reset: after loading in=0xFF, pulse rst_n=0 between edges -> out_q, msb_idx, msb_vld, peak_idx all 0 before the next edge; out stays 1.
REQ-033 Peak (macro on): in sequence 0x04, 0x40, 0x02 -> peak_idx 2, 6, 6; then clr=1 with in=0x10 on one edge -> peak_idx=0; next edge with clr=0 -> 4.
REQ-034 Macro off: build compiles without peak_idx; REQ-029..032 pass unchanged.

Source files
------------

// File: rtl/take_msb.sv
// Threshold flag on an unsigned word, plus a registered flag and leading-one index.
// Define TAKE_MSB_PEAK_EN to add peak_idx: the highest index seen since reset or clr.
module take_msb #(
    parameter int WIDTH   = 8,
    parameter int MSB_BIT = 3,
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             clr,
    output logic             out,
    output logic             out_q,
    output logic [IW-1:0]    msb_idx,
    output logic             msb_vld
`ifdef TAKE_MSB_PEAK_EN
    ,
    output logic [IW-1:0]    peak_idx
`endif
);

    typedef struct packed {
        logic          flag;
        logic [IW-1:0] idx;
        logic          vld;
    } cap_t;

    cap_t          cap_nxt;
    cap_t          cap_q;
    logic [IW-1:0] idx_nxt;

    // Flag is purely combinational and must track in even while in reset.
    assign out = |in[WIDTH-1:MSB_BIT];

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) idx_nxt = IW'(i);
        end
    end

    assign cap_nxt = '{flag: out, idx: idx_nxt, vld: |in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap_q <= '0;
        else        cap_q <= cap_nxt;
    end

    assign out_q   = cap_q.flag;
    assign msb_idx = cap_q.idx;
    assign msb_vld = cap_q.vld;

`ifdef TAKE_MSB_PEAK_EN
    logic [IW-1:0] peak_q;

    // Clear wins over a simultaneous capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               peak_q <= '0;
        else if (clr)                             peak_q <= '0;
        else if (cap_nxt.vld && idx_nxt > peak_q) peak_q <= idx_nxt;
    end

    assign peak_idx = peak_q;
`else
    wire clr_unused = clr;
`endif

endmodule

// File: tb/tb_take_msb.sv
// Directed bench for take_msb; peak checks compile in with TAKE_MSB_PEAK_EN.
module tb_take_msb;

    localparam int WIDTH = 8;
    localparam int IW    = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic             clr;
    logic             out;
    logic             out_q;
    logic [IW-1:0]    msb_idx;
    logic             msb_vld;
`ifdef TAKE_MSB_PEAK_EN
    logic [IW-1:0]    peak_idx;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    take_msb #(.WIDTH(WIDTH), .MSB_BIT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .clr     (clr),
        .out     (out),
        .out_q   (out_q),
        .msb_idx (msb_idx),
        .msb_vld (msb_vld)
`ifdef TAKE_MSB_PEAK_EN
        ,
        .peak_idx(peak_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic step(input logic [WIDTH-1:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clr   = 1'b0;
        in    = 8'h5A;
        #2;
        n_checks++;
        if (out_q !== 1'b0) begin n_fail++; $display("FAIL reset_out_q: got %b want 0", out_q); end
        n_checks++;
        if (msb_idx !== 3'd0) begin n_fail++; $display("FAIL reset_msb_idx: got %0d want 0", msb_idx); end
        n_checks++;
        if (msb_vld !== 1'b0) begin n_fail++; $display("FAIL reset_msb_vld: got %b want 0", msb_vld); end
        n_checks++;
        if (out !== 1'b1) begin n_fail++; $display("FAIL reset_out_follows_in: got %b want 1", out); end
`ifdef TAKE_MSB_PEAK_EN
        n_checks++;
        if (peak_idx !== 3'd0) begin n_fail++; $display("FAIL reset_peak: got %0d want 0", peak_idx); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep;
        logic [WIDTH-1:0] vin [11];
        logic             vexp[11];
        vin[0] = 8'hFF; vexp[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vin[i+1]  = 8'(i);
            vexp[i+1] = (i >= 8);
        end
        for (int i = 0; i < 11; i++) begin
            in = vin[i];
            #10;
            n_checks++;
            if (out !== vexp[i]) begin
                n_fail++;
                $display("FAIL comb_out in=%h: got %b want %b", vin[i], out, vexp[i]);
            end
        end
    endtask

    task automatic test_registered;
        step(8'h09);
        n_checks++;
        if (out_q !== 1'b1) begin n_fail++; $display("FAIL reg_out_q_09: got %b want 1", out_q); end
        n_checks++;
        if (msb_idx !== 3'd3) begin n_fail++; $display("FAIL reg_idx_09: got %0d want 3", msb_idx); end
        n_checks++;
        if (msb_vld !== 1'b1) begin n_fail++; $display("FAIL reg_vld_09: got %b want 1", msb_vld); end
        step(8'h00);
        n_checks++;
        if (out_q !== 1'b0) begin n_fail++; $display("FAIL reg_out_q_00: got %b want 0", out_q); end
        n_checks++;
        if (msb_idx !== 3'd0) begin n_fail++; $display("FAIL reg_idx_00: got %0d want 0", msb_idx); end
        n_checks++;
        if (msb_vld !== 1'b0) begin n_fail++; $display("FAIL reg_vld_00: got %b want 0", msb_vld); end
    endtask

    task automatic test_prio;
        logic [WIDTH-1:0] vin [6];
        logic [IW-1:0]    vidx[6];
        logic             vq  [6];
        vin[0] = 8'h01; vidx[0] = 3'd0; vq[0] = 1'b0;
        vin[1] = 8'h80; vidx[1] = 3'd7; vq[1] = 1'b1;
        vin[2] = 8'hFF; vidx[2] = 3'd7; vq[2] = 1'b1;
        vin[3] = 8'h24; vidx[3] = 3'd5; vq[3] = 1'b1;
        vin[4] = 8'h06; vidx[4] = 3'd2; vq[4] = 1'b0;
        vin[5] = 8'h10; vidx[5] = 3'd4; vq[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(vin[i]);
            n_checks++;
            if (msb_idx !== vidx[i]) begin
                n_fail++;
                $display("FAIL prio_idx in=%h: got %0d want %0d", vin[i], msb_idx, vidx[i]);
            end
            n_checks++;
            if (msb_vld !== 1'b1 || out_q !== vq[i]) begin
                n_fail++;
                $display("FAIL prio_vld_q in=%h: got vld=%b q=%b want vld=1 q=%b",
                         vin[i], msb_vld, out_q, vq[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        step(8'hFF);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_q !== 1'b0 || msb_idx !== 3'd0 || msb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_regs: got q=%b idx=%0d vld=%b want 0 0 0", out_q, msb_idx, msb_vld);
        end
        n_checks++;
        if (out !== 1'b1) begin n_fail++; $display("FAIL async_reset_out: got %b want 1", out); end
`ifdef TAKE_MSB_PEAK_EN
        n_checks++;
        if (peak_idx !== 3'd0) begin n_fail++; $display("FAIL async_reset_peak: got %0d want 0", peak_idx); end
`endif
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (msb_idx !== 3'd7 || msb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_after_reset: got idx=%0d vld=%b want 7 1", msb_idx, msb_vld);
        end
        // Return to zero state for the following scenario.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

`ifdef TAKE_MSB_PEAK_EN
    task automatic test_peak;
        logic [WIDTH-1:0] vin [3];
        logic [IW-1:0]    vpk [3];
        vin[0] = 8'h04; vpk[0] = 3'd2;
        vin[1] = 8'h40; vpk[1] = 3'd6;
        vin[2] = 8'h02; vpk[2] = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step(vin[i]);
            n_checks++;
            if (peak_idx !== vpk[i]) begin
                n_fail++;
                $display("FAIL peak_track in=%h: got %0d want %0d", vin[i], peak_idx, vpk[i]);
            end
        end
        @(negedge clk);
        clr = 1'b1;
        in  = 8'h10;
        @(posedge clk);
        #1;
        n_checks++;
        if (peak_idx !== 3'd0) begin n_fail++; $display("FAIL peak_clr_priority: got %0d want 0", peak_idx); end
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (peak_idx !== 3'd4) begin n_fail++; $display("FAIL peak_after_clr: got %0d want 4", peak_idx); end
    endtask
`else
    task automatic test_clr_ignored;
        step(8'h20);
        @(negedge clk);
        clr = 1'b1;
        in  = 8'h08;
        @(posedge clk);
        #1;
        n_checks++;
        if (msb_idx !== 3'd3 || msb_vld !== 1'b1 || out_q !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_ignored: got idx=%0d vld=%b q=%b want 3 1 1", msb_idx, msb_vld, out_q);
        end
        clr = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_comb_sweep;
        test_registered;
        test_prio;
        test_async_reset;
`ifdef TAKE_MSB_PEAK_EN
        test_peak;
`else
        test_clr_ignored;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
